delay_scheduler: RTL

- Shared timed-delay engine for the display/LCD init and animation sequencers.
- One prescaler and one countdown counter are shared among NUM_REQ requesters, granted round-robin.
- Each granted requester gets a delay of K prescaler ticks, then a one-cycle done pulse.
- Replaces per-sequencer divided clocks; everything runs in the clk domain using tick enables only.

---
 rtl/delay_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/delay_scheduler.sv
// delay_scheduler: round-robin shared prescaler/countdown engine; each owner gets K ticks then a done pulse.
// Optional build macro DELAY_ABORT_EN adds an abort input that ends a running delay early.
`timescale 1ns/1ps
`default_nettype none

module delay_scheduler #(
    parameter int NUM_REQ  = 2,
    parameter int PRESCALE = 25000,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef DELAY_ABORT_EN
    input  logic                     abort,
`endif
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] ticks_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     tick
);

    localparam int c_PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PS_W-1:0]  c_PS_LAST = c_PS_W'(PRESCALE - 1);
    localparam logic [c_IDX_W-1:0] c_RR_INIT = c_IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_busy;
    logic                 r_tick;
    logic [c_PS_W-1:0]    r_ps;
    logic [CNT_W-1:0]     r_rem;
    logic [c_IDX_W-1:0]   r_rr;
    logic [c_IDX_W-1:0]   r_owner;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_sel;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [CNT_W-1:0]     w_k;
    logic                 w_abort;

`ifdef DELAY_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Round-robin search: first requester at or after the one following the last owner.
    always_comb begin : p_arb
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_sel    = '0;
        w_onehot = '0;
        w_k      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = (int'(r_rr) + 1 + i) % NUM_REQ;
            if (!w_found && req[v_idx]) begin
                w_found         = 1'b1;
                w_sel           = c_IDX_W'(v_idx);
                w_onehot[v_idx] = 1'b1;
                w_k             = ticks_in[v_idx*CNT_W +: CNT_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
            r_ps    <= '0;
            r_rem   <= '0;
            r_rr    <= c_RR_INIT;
            r_owner <= '0;
        end else begin
            r_tick <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_onehot;
                        r_owner <= w_sel;
                        r_rem   <= w_k;
                        r_ps    <= '0;
                        r_busy  <= 1'b1;
                        // A zero-length delay completes in the same cycle the grant appears.
                        if (w_k == '0) begin
                            r_state <= S_DONE;
                            r_done  <= w_onehot;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                        r_ps    <= '0;
                        r_rem   <= '0;
                    end else if (r_ps == c_PS_LAST) begin
                        r_ps   <= '0;
                        r_tick <= 1'b1;
                        r_rem  <= r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            r_state <= S_DONE;
                            r_done  <= r_grant;
                        end
                    end else begin
                        r_ps <= r_ps + c_PS_W'(1);
                    end
                end
                S_DONE: begin
                    r_rr    <= r_owner;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign tick  = r_tick;

endmodule

`default_nettype wire
